memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  MEM stage: sits between execute and writeback. Takes execute's ALU result, rs2 value and control.
//  Runs a req/ack transaction to data memory for loads and stores, with byte/half/word sizing.
//  Stalls execute while an access is in flight. Drives the MEM/WB register that feeds writeback and mem_wb forwarding.
// PARAMETERS
//  ADDR_W  32  data-memory address width
//  DATA_W  32  datapath width (fixed at 32; other values unsupported)
// PORTS
//  clk                 in   1   clock, all state on posedge
//  rst                 in   1   reset, asynchronous, active-low
//  in_MemRead          in   1   instruction is a load
//  in_MemWrite         in   1   instruction is a store
//  in_RegWrite         in   1   instruction writes rd
//  in_RegDest          in   5   rd index
//  in_MemToReg         in   1   WB selects load data
//  in_MemSize          in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  in_result           in   32  ALU result / effective address
//  in_rs2_value        in   32  store data
//  mem_stall           out  1   stall to execute (its stall input)
//  dmem_req            out  1   access request, held until ack
//  dmem_we             out  1   1 = write
//  dmem_addr           out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata          out  32  lane-replicated store data
//  dmem_wstrb          out  4   byte-lane write enables
//  dmem_ack            in   1   access complete; dmem_rdata valid this cycle for reads
//  dmem_rdata          in   32  read word
//  out_RegWrite        out  1   MEM/WB: write rd
//  out_RegDest         out  5   MEM/WB: rd
//  out_MemToReg        out  1   MEM/WB: select load data
//  out_AluResult       out  32  MEM/WB: ALU result passthrough
//  out_data_out        out  32  MEM/WB: extended load data
//  out_misaligned      out  1   one-cycle misalign flag (tied 0 without the macro)
// BEHAVIOUR
//  Reset: every output and all internal registers are 0; FSM is IDLE; dmem_req drops immediately.
//  Reset in ACCESS abandons the transaction; the late ack is ignored.
//  FSM IDLE/ACCESS, one instruction accepted per IDLE cycle.
//  IDLE, no mem op: MEM/WB loads the in_* fields at the next edge (latency 1); out_data_out<=0.
//  IDLE, mem op: latch addr, size, wdata, wstrb, we and ctrl; go to ACCESS; MEM/WB gets a bubble (out_RegWrite<=0).
//  ACCESS: dmem_req=1, with dmem_* stable from registers; mem_stall=1 for the whole state, including the ack cycle.
//  On the ack edge: MEM/WB loads the latched ctrl, with out_data_out = extended rdata; FSM returns to IDLE.
//  In the IDLE cycle after ack, mem_stall=0 and the instruction held in execute is consumed. No instruction is lost.
//  Minimum mem op: 2 cycles (accept, ACCESS with same-cycle ack); plus one cycle per extra wait state.
//  Store MEM/WB: out_RegWrite follows in_RegWrite (0 for stores); out_data_out=0.
//  Lanes, with o=addr[1:0]:
//   B wstrb=1<<o, wdata={4{rs2[7:0]}}
//   H wstrb=3<<{o[1],1'b0}, wdata={2{rs2[15:0]}}
//   W wstrb=4'hF, wdata=rs2
//  Loads: select byte/half from rdata by o; sign-extend B/H, zero-extend BU/HU.
//  Unknown in_MemSize: treated as W.
// CONFIGURATION
//  MEMORY_MISALIGN_TRAP_EN defined:
//   H with o[0]=1, or W with o!=0: no dmem_req and no ACCESS.
//   MEM/WB gets out_RegWrite=0 and out_misaligned=1 for one cycle; out_AluResult carries the bad address.
//  Undefined: low address bits are forced (H clears o[0], W clears o); out_misaligned is constant 0.
// STRUCTURE
//  mem_defs.vh: localparams for funct3 size codes and the IDLE/ACCESS state encoding.
//  Sub-module load_align: combinational rdata + o + size -> extended 32-bit load value.
// TESTING
//  LW @0x100, ack on first ACCESS cycle, rdata=0xDEADBEEF -> out_data_out=0xDEADBEEF 2 cycles after accept; mem_stall high 1 cycle.
//  LB @0x103, rdata=0x80FFFFFF -> 0xFFFFFF80; LBU -> 0x00000080; LHU @0x102 -> 0x000080FF.
//  SB @0x201, rs2=0x12345678 -> dmem_wstrb=4'b0010, dmem_wdata=0x78787878, dmem_addr=0x200.
//  Ack delayed 3 cycles -> dmem_req and dmem_addr stable, mem_stall high 4 cycles; next ALU op reaches MEM/WB 1 cycle after ack.
//  Back-to-back ADD x5, then SW -> ADD in MEM/WB after 1 cycle (RegWrite=1, rd=5); SW gives a bubble then completes.
//  rst low during ACCESS, ack arrives later -> dmem_req=0 at once, all outputs 0; with MEMORY_MISALIGN_TRAP_EN, LW @0x102 -> out_misaligned=1, no req.

Source files
------------

// File: rtl/memory_access_pkg.sv
// memory_access_pkg: funct3 size codes, MEM-stage FSM states and lane helpers.
package memory_access_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    function automatic logic is_byte(input logic [2:0] s);
        return s == SZ_B || s == SZ_BU;
    endfunction

    function automatic logic is_half(input logic [2:0] s);
        return s == SZ_H || s == SZ_HU;
    endfunction

    // Any code that is neither byte nor half behaves as a word access.
    function automatic logic [3:0] lane_strb(input logic [2:0] s, input logic [1:0] o);
        return is_byte(s) ? 4'b0001 << o : is_half(s) ? 4'b0011 << {o[1], 1'b0} : 4'hF;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] s, input logic [31:0] d);
        return is_byte(s) ? {4{d[7:0]}} : is_half(s) ? {2{d[15:0]}} : d;
    endfunction

    function automatic logic misaligned(input logic [2:0] s, input logic [1:0] o);
        return is_half(s) ? o[0] : is_byte(s) ? 1'b0 : o != 2'b00;
    endfunction

    function automatic logic [1:0] force_off(input logic [2:0] s, input logic [1:0] o);
        return is_half(s) ? {o[1], 1'b0} : is_byte(s) ? o : 2'b00;
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if: req/ack data-memory bus between the MEM stage and data memory.
interface memory_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic              ack;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W/8-1:0] wstrb;

    modport master(output req, we, addr, wdata, wstrb, input ack, rdata);
    modport slave(input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/memory_access_load_align.sv
// memory_access_load_align: picks the addressed byte/half out of a read word and extends it.
module memory_access_load_align
    import memory_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign o_data = i_size == SZ_B  ? {{24{w_byte[7]}}, w_byte} :
                    i_size == SZ_BU ? {24'h0, w_byte} :
                    i_size == SZ_H  ? {{16{w_half[15]}}, w_half} :
                    i_size == SZ_HU ? {16'h0, w_half} : i_rdata;
endmodule

// File: rtl/memory_access.sv
// memory_access: MEM stage with req/ack data-memory FSM and MEM/WB register.
// Define MEMORY_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of forcing alignment.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_MemRead,
    input  logic              in_MemWrite,
    input  logic              in_RegWrite,
    input  logic [4:0]        in_RegDest,
    input  logic              in_MemToReg,
    input  logic [2:0]        in_MemSize,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_rs2_value,
    output logic              mem_stall,
    memory_access_if.master   dmem,
    output logic              out_RegWrite,
    output logic [4:0]        out_RegDest,
    output logic              out_MemToReg,
    output logic [DATA_W-1:0] out_AluResult,
    output logic [DATA_W-1:0] out_data_out,
    output logic              out_misaligned
);
    state_t            r_state, w_next;
    logic              w_mem_op, w_trap, w_go;
    logic [1:0]        w_off;
    logic [DATA_W-1:0] w_load;
    logic              r_we, r_rw, r_m2r;
    logic [4:0]        r_rd;
    logic [2:0]        r_size;
    logic [1:0]        r_off;
    logic [3:0]        r_wstrb;
    logic [DATA_W-1:0] r_wdata, r_result;

    always_comb begin
        w_mem_op = in_MemRead | in_MemWrite;
`ifdef MEMORY_MISALIGN_TRAP_EN
        w_trap   = w_mem_op & misaligned(in_MemSize, in_result[1:0]);
        w_off    = in_result[1:0];
`else
        w_trap   = 1'b0;
        w_off    = force_off(in_MemSize, in_result[1:0]);
`endif
        w_go     = r_state == IDLE && w_mem_op && !w_trap;
        w_next   = r_state == IDLE ? (w_go ? ACCESS : IDLE) : (dmem.ack ? IDLE : ACCESS);
    end

    assign mem_stall  = r_state == ACCESS;
    assign dmem.req   = mem_stall;
    assign dmem.we    = r_we;
    assign dmem.addr  = {r_result[ADDR_W-1:2], 2'b00};
    assign dmem.wdata = r_wdata;
    assign dmem.wstrb = r_wstrb;

    memory_access_load_align u_align (
        .i_rdata(dmem.rdata),
        .i_off  (r_off),
        .i_size (r_size),
        .o_data (w_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_rw     <= 1'b0;
            r_m2r    <= 1'b0;
            r_rd     <= '0;
            r_size   <= '0;
            r_off    <= '0;
            r_wstrb  <= '0;
            r_wdata  <= '0;
            r_result <= '0;
        end else if (w_go) begin
            r_we     <= in_MemWrite;
            r_rw     <= in_RegWrite;
            r_m2r    <= in_MemToReg;
            r_rd     <= in_RegDest;
            r_size   <= in_MemSize;
            r_off    <= w_off;
            r_wstrb  <= in_MemWrite ? lane_strb(in_MemSize, w_off) : 4'h0;
            r_wdata  <= lane_wdata(in_MemSize, in_rs2_value);
            r_result <= in_result;
        end
    end

    // A memory op (or trap) places a bubble; the real record lands on the ack edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_RegWrite   <= 1'b0;
            out_RegDest    <= '0;
            out_MemToReg   <= 1'b0;
            out_AluResult  <= '0;
            out_data_out   <= '0;
            out_misaligned <= 1'b0;
        end else if (r_state == IDLE) begin
            out_RegWrite   <= in_RegWrite & ~w_mem_op;
            out_RegDest    <= in_RegDest;
            out_MemToReg   <= in_MemToReg;
            out_AluResult  <= in_result;
            out_data_out   <= '0;
            out_misaligned <= w_trap;
        end else if (dmem.ack) begin
            out_RegWrite   <= r_rw;
            out_RegDest    <= r_rd;
            out_MemToReg   <= r_m2r;
            out_AluResult  <= r_result;
            out_data_out   <= r_we ? '0 : w_load;
            out_misaligned <= 1'b0;
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: random instruction stream against a byte-level memory model with a scoreboard.
module tb_memory_access;
    logic        clk = 1'b0, rst = 1'b0;
    logic        in_MemRead = 0, in_MemWrite = 0, in_RegWrite = 0, in_MemToReg = 0;
    logic [4:0]  in_RegDest = 0;
    logic [2:0]  in_MemSize = 0;
    logic [31:0] in_result = 0, in_rs2_value = 0;
    logic        mem_stall, out_RegWrite, out_MemToReg, out_misaligned;
    logic [4:0]  out_RegDest;
    logic [31:0] out_AluResult, out_data_out;

    always #5 clk = ~clk;

    memory_access_if #(.ADDR_W(32), .DATA_W(32)) dmem ();

    memory_access dut (
        .clk(clk), .rst(rst),
        .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite), .in_RegWrite(in_RegWrite),
        .in_RegDest(in_RegDest), .in_MemToReg(in_MemToReg), .in_MemSize(in_MemSize),
        .in_result(in_result), .in_rs2_value(in_rs2_value),
        .mem_stall(mem_stall), .dmem(dmem),
        .out_RegWrite(out_RegWrite), .out_RegDest(out_RegDest), .out_MemToReg(out_MemToReg),
        .out_AluResult(out_AluResult), .out_data_out(out_data_out), .out_misaligned(out_misaligned)
    );

    typedef struct {logic rw; logic [4:0] rd; logic m2r; logic [31:0] alu; logic [31:0] data; logic mis;} rec_t;
    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} bus_t;

    rec_t        exp_q[$];
    bus_t        bus_q[$];
    int          n_cmp = 0, n_err = 0;
    bit          en_mon = 0, en_slave = 0, man_ack = 0;
    logic [7:0]  mdl[64];
    logic [31:0] smem[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] s);
        return (s == 3'd0 || s == 3'd4) ? 1 : (s == 3'd1 || s == 3'd5) ? 2 : 4;
    endfunction

    function automatic bit trap(input logic [2:0] s, input logic [31:0] a);
`ifdef MEMORY_MISALIGN_TRAP_EN
        return (a % nbytes(s)) != 0;
`else
        return (a == 32'hFFFF_FFFF) && (s == 3'd7) && 1'b0;
`endif
    endfunction

    task automatic issue(input bit rd_, input bit wr_, input bit rw_, input logic [4:0] rd, input bit m2r,
                         input logic [2:0] sz, input logic [31:0] res, input logic [31:0] rs2);
        rec_t r;
        bus_t b;
        int n, ea;
        logic [31:0] v;
        in_MemRead = rd_; in_MemWrite = wr_; in_RegWrite = rw_; in_RegDest = rd;
        in_MemToReg = m2r; in_MemSize = sz; in_result = res; in_rs2_value = rs2;
        n = nbytes(sz);
        r = '{rw_, rd, m2r, res, 32'h0, 1'b0};
        if ((rd_ || wr_) && trap(sz, res)) begin
            r.rw = 1'b0; r.mis = 1'b1;
        end else if (rd_ || wr_) begin
            ea = int'(res - 32'h100) - int'(res % n);
            ea = ea + int'(res % n) - int'(res % n);
            ea = int'(res - 32'h100) - int'(res % n);
            b.we = wr_;
            b.addr = res & ~32'h3;
            b.wdata = n == 1 ? {4{rs2[7:0]}} : n == 2 ? {2{rs2[15:0]}} : rs2;
            b.wstrb = 4'((32'd1 << n) - 1) << (ea % 4);
            bus_q.push_back(b);
            if (wr_) begin
                for (int i = 0; i < n; i++) mdl[ea + i] = rs2[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v | (32'(mdl[ea + i]) << (8 * i));
                if (n < 4 && sz[2] == 1'b0 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                r.data = v;
            end
        end
        exp_q.push_back(r);
        for (int c = 0; mem_stall; c++) begin
            if (c > 50) begin
                $display("FAIL stall_timeout: mem_stall stuck high for %0d cycles", c);
                $fatal(1, "stall timeout");
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // Monitor: a MEM/WB record is due after an IDLE non-mem (or trapped) cycle or an ack cycle.
    logic m_memop, m_st, m_ack, m_tr;
    rec_t m_r;
    always @(posedge clk) if (en_mon && rst) begin
        m_memop = in_MemRead | in_MemWrite;
        m_st = mem_stall;
        m_ack = dmem.req & dmem.ack;
        m_tr = m_memop & trap(in_MemSize, in_result);
        #1;
        if ((!m_st && (!m_memop || m_tr)) || m_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_record", 32'(out_RegWrite), 32'hX);
            end else begin
                m_r = exp_q.pop_front();
                chk("RegWrite", 32'(out_RegWrite), 32'(m_r.rw));
                chk("AluResult", out_AluResult, m_r.alu);
                chk("misaligned", 32'(out_misaligned), 32'(m_r.mis));
                if (!m_r.mis) begin
                    chk("RegDest", 32'(out_RegDest), 32'(m_r.rd));
                    chk("MemToReg", 32'(out_MemToReg), 32'(m_r.m2r));
                    chk("data_out", out_data_out, m_r.data);
                end
            end
        end else if (!m_st && m_memop) begin
            chk("bubble_RegWrite", 32'(out_RegWrite), 32'h0);
        end
    end

    // Data-memory slave with 0..3 random wait states.
    bit s_busy = 0, s_post = 0;
    int s_wait = 0;
    logic [31:0] s_addr;
    bus_t s_b;
    always @(negedge clk) begin
        if (!en_slave || !rst) begin
            dmem.ack = man_ack; s_busy = 0; s_post = 0;
        end else begin
            if (s_post) begin
                chk("req_drop", 32'(dmem.req), 32'h0);
                chk("stall_drop", 32'(mem_stall), 32'h0);
                s_post = 0;
            end
            dmem.ack = 1'b0;
            if (dmem.req && !s_busy) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_req", 32'(dmem.req), 32'h0);
                    s_b = '{1'b0, 32'h100, 32'h0, 4'h0};
                end else s_b = bus_q.pop_front();
                chk("bus_we", 32'(dmem.we), 32'(s_b.we));
                chk("bus_addr", dmem.addr, s_b.addr);
                if (s_b.we) begin
                    chk("bus_wdata", dmem.wdata, s_b.wdata);
                    chk("bus_wstrb", 32'(dmem.wstrb), 32'(s_b.wstrb));
                end
                s_busy = 1; s_wait = $urandom_range(0, 3); s_addr = dmem.addr;
            end
            if (s_busy) begin
                chk("addr_stable", dmem.addr, s_addr);
                chk("stall_held", 32'(mem_stall), 32'h1);
                if (s_wait == 0) begin
                    dmem.ack = 1'b1; s_busy = 0; s_post = 1;
                    if (dmem.we) begin
                        for (int i = 0; i < 4; i++)
                            if (dmem.wstrb[i]) smem[s_addr[5:2]][8*i +: 8] = dmem.wdata[8*i +: 8];
                    end else dmem.rdata = smem[s_addr[5:2]];
                end else begin
                    s_wait--; dmem.rdata = $urandom;
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        logic [2:0] sz;
        for (int i = 0; i < 16; i++) begin
            w = i == 0 ? 32'hDEADBEEF : i == 1 ? 32'h80FFFFFF : $urandom;
            smem[i] = w;
            for (int j = 0; j < 4; j++) mdl[4*i + j] = w[8*j +: 8];
        end
        dmem.rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_req", 32'(dmem.req), 0);
        chk("rst_RegWrite", 32'(out_RegWrite), 0);
        chk("rst_AluResult", out_AluResult, 0);
        chk("rst_data_out", out_data_out, 0);
        chk("rst_misaligned", 32'(out_misaligned), 0);
        rst = 1; en_mon = 1; en_slave = 1;
        @(negedge clk);
        issue(1, 0, 1, 5'd7, 1, 3'd2, 32'h100, 0);
        issue(1, 0, 1, 5'd8, 1, 3'd0, 32'h107, 0);
        issue(1, 0, 1, 5'd9, 1, 3'd4, 32'h107, 0);
        issue(1, 0, 1, 5'd10, 1, 3'd5, 32'h106, 0);
        issue(0, 1, 0, 5'd0, 0, 3'd0, 32'h109, 32'h12345678);
        issue(0, 0, 1, 5'd5, 0, 3'd0, 32'h0000_0042, 0);
        issue(0, 1, 0, 5'd0, 0, 3'd2, 32'h10C, 32'hCAFEF00D);
        issue(1, 0, 1, 5'd11, 1, 3'd2, 32'h108, 0);
        issue(1, 0, 1, 5'd12, 1, 3'd2, 32'h102, 0);
        for (int k = 0; k < 300; k++) begin
            sz = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1: issue(0, 0, 1'($urandom), 5'($urandom), 1'($urandom), sz, $urandom, $urandom);
                2: issue(1, 0, 1, 5'($urandom), 1, sz, 32'h100 + $urandom_range(0, 63), $urandom);
                default: issue(0, 1, 0, 5'($urandom), 0, sz, 32'h100 + $urandom_range(0, 63), $urandom);
            endcase
        end
        issue(0, 0, 0, 5'd0, 0, 3'd0, 32'h0, 0);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
        chk("drain_left", 32'(exp_q.size()), 0);
        en_mon = 0; en_slave = 0;
        issue(0, 0, 0, 5'd0, 0, 3'd0, 32'h0, 0);
        in_MemRead = 1; in_RegWrite = 1; in_MemSize = 3'd2; in_result = 32'h100; in_RegDest = 5'd3;
        @(negedge clk);
        chk("access_req", 32'(dmem.req), 1);
        in_MemRead = 0; in_RegWrite = 0; in_MemSize = 0; in_result = 0; in_RegDest = 0;
        #2 rst = 0;
        #1;
        chk("abort_req", 32'(dmem.req), 0);
        chk("abort_stall", 32'(mem_stall), 0);
        chk("abort_RegWrite", 32'(out_RegWrite), 0);
        chk("abort_AluResult", out_AluResult, 0);
        @(negedge clk);
        rst = 1; man_ack = 1;
        @(negedge clk);
        man_ack = 0;
        @(negedge clk);
        #1;
        chk("late_ack_stall", 32'(mem_stall), 0);
        chk("late_ack_req", 32'(dmem.req), 0);
        chk("late_ack_RegWrite", 32'(out_RegWrite), 0);
        chk("late_ack_data", out_data_out, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
